// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch unit: widths, fetch state and the
// {pc, instr} record that travels through the fetch queue toward decode.
package fetch_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 32;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// In-order circular buffer of fetch entries; flush empties it and wins over
// any push or pop in the same cycle. Head is read straight from storage.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output logic         full,
  output logic         empty,
  output fetch_entry_t head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W:0]   count;
  fetch_entry_t     slots [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_COUNT);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = slots[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{PTR_W{1'b0}}, do_push} - {{PTR_W{1'b0}}, do_pop};
    end
  end

  // Storage is cleared on reset so the head reads as zero while empty.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) slots[i] <= '0;
    end else if (do_push && !flush) begin
      slots[wr_ptr] <= din;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch: owns the PC, reads the combinational instruction memory,
// queues {pc, instr} pairs for decode, handles redirects and halts on a bad PC.
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC    = 32'h0000_0000,
  parameter int                MEM_SIZE    = 128,
  parameter int                QUEUE_DEPTH = 2
) (
  input  logic               clk,
  input  logic               reset,
  output logic [ADDR_W-1:0]  fetch_addr,
  input  logic [INSTR_W-1:0] fetch_instr,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc,
  output logic               fault
);

  fetch_state_t      state_reg;
  fetch_state_t      state_next;
  logic [ADDR_W-1:0] pc_reg;
  logic [ADDR_W-1:0] pc_next;
  logic              pc_legal;
  logic              push;
  logic              pop;
  logic              flush;
  logic              q_full;
  logic              q_empty;
  fetch_entry_t      q_head;
  fetch_entry_t      q_din;

  // Word-index compare against the memory depth; no division needed.
  assign pc_legal = (pc_reg[1:0] == 2'b00) &&
                    ({2'b00, pc_reg[ADDR_W-1:2]} < ADDR_W'(MEM_SIZE));

  assign pop        = out_valid && out_ready;
  assign fetch_addr = pc_reg;
  assign out_valid  = !q_empty;
  assign out_pc     = q_head.pc;
  assign out_instr  = q_head.instr;
  assign fault      = (state_reg == HALT);
  assign q_din      = '{pc: pc_reg, instr: fetch_instr};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= RUN;
      pc_reg    <= RESET_PC;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (state_reg == RUN && !redirect_valid && !pc_legal) state_next = HALT;
  end

  // Redirect outranks both push and pop; HALT only lets the queue drain.
  always_comb begin
    push    = 1'b0;
    flush   = 1'b0;
    pc_next = pc_reg;
    if (state_reg == RUN) begin
      if (redirect_valid) begin
        flush   = 1'b1;
        pc_next = redirect_pc;
      end else if (pc_legal && (!q_full || pop)) begin
        push    = 1'b1;
        pc_next = pc_reg + ADDR_W'(4);
      end
    end
  end

  fetch_queue #(
    .DEPTH(QUEUE_DEPTH)
  ) u_queue (
    .clk  (clk),
    .reset(reset),
    .push (push),
    .pop  (pop),
    .flush(flush),
    .din  (q_din),
    .full (q_full),
    .empty(q_empty),
    .head (q_head)
  );

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction fetch unit: the initiator on the instruction-memory read port. Owns the program counter, drives the word-aligned byte fetch address into the combinational instruction memory, captures the returned instruction word, and buffers `{pc, instruction}` pairs in a small in-order queue toward decode with a valid/ready handshake. Accepts taken-branch/jump redirects from execute, which flush the queue, and halts with a fault flag on an illegal fetch address.

## Interface
- `RESET_PC`, 32'h0000_0000: byte address fetched first after reset.
- `MEM_SIZE`, 128: instruction memory depth in 32-bit words; legal addresses are 0 .. 4*MEM_SIZE-4.
- `QUEUE_DEPTH`, 2: fetch queue entries, power of two, ≥2.

- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low; 0 clears all state.
- `fetch_addr`  out  32  byte address to instruction memory `readAdress`.
- `fetch_instr`  in  32  instruction word from memory, valid in the same cycle.
- `redirect_valid`  in  1  execute requests a PC change this cycle.
- `redirect_pc`  in  32  target byte address.
- `out_valid`  out  1  queue head valid.
- `out_ready`  in  1  decode accepts head.
- `out_instr`  out  32  head instruction.
- `out_pc`  out  32  byte address of head instruction.
- `fault`  out  1  sticky; an illegal address was reached.

## Operation
- State machine: `RUN`, `HALT`. Reset enters `RUN` with `pc = RESET_PC`, queue empty, `fault = 0`.
- `fetch_addr = pc`. This is a registered value; no combinational path from any input.
- Pop: `out_valid && out_ready`. Push condition in `RUN`: no redirect, `pc` legal, and queue not full or a pop occurs in the same cycle.
- On push, `{pc, fetch_instr}` is enqueued and `pc <= pc + 4`. With no push, `pc` holds.
- Simultaneous push and pop on a full queue is legal, and occupancy is unchanged. Occupancy never exceeds `QUEUE_DEPTH` and never underflows.
- Legal `pc` means `pc[1:0] == 0` and `pc[31:2] < MEM_SIZE`. This is a compare on bits [31:2]; no divider is used.
- `pc` illegal in `RUN` with no redirect: no push, next state is `HALT`, `fault <= 1`. Entries already queued still drain to decode.
- Redirect in `RUN`, which has priority over push and pop:
  - Queue is flushed to empty. A pop presented in the same cycle is discarded; decode must not treat it as accepted.
  - `pc <= redirect_pc` and no push occurs that cycle.
  - A misaligned or out-of-range `redirect_pc` is not rejected immediately. The fault is raised on the next cycle by the legality check.
- `HALT`: redirects and pushes are ignored, `pc` holds, the queue drains normally. Only `reset` leaves `HALT`.
- The queue is a circular buffer with wrapping read/write pointers and a count. Pointer width is `$clog2(QUEUE_DEPTH)`. The count has one extra bit.

## Timing
- Reset values: `fetch_addr = RESET_PC`, `out_valid = 0`, `out_instr = 0`, `out_pc = 0`, `fault = 0`.
- Fetch-to-decode latency: the instruction at `pc` is presented at `out_*` one cycle after the push edge.
  - First `out_valid` rises on the first rising edge after `reset` deasserts.
- Redirect latency: the first target instruction appears at `out_*` two edges after the redirect edge.
  - Edge 1: `pc` loaded.
  - Edge 2: pushed.
- Throughput: one instruction per cycle while `out_ready` stays high.
- `out_*` are driven from queue storage (head entry). `out_instr` and `out_pc` hold while `out_valid && !out_ready`.
- `fault` asserts on the edge that enters `HALT`.
- Asynchronous reset mid-operation immediately empties the queue and forces every output to its reset value, with no clock required.

## Structure
- Shared package `fetch_pkg`:
  - `INSTR_W = 32`, `ADDR_W = 32`.
  - State enum `{RUN, HALT}`.
  - Struct `fetch_entry_t {pc, instr}`.
- Sub-module `fetch_queue`: parameterised synchronous FIFO of `fetch_entry_t`. Ports are `push`, `pop`, `flush`, `full`, `empty`, `head`, with async active-low `reset`.
- Top level holds the PC register, legality check, push/redirect control and the state machine. Pair with a memory model holding known words at 0, 4, 8.

## Test plan
- **Sequential fetch:** reset release with `out_ready = 1` and memory words 0–2 = 32'h00011020, 32'h00642820, 32'hae010000 -> `out_pc` 0, 4, 8 on consecutive cycles with the matching `out_instr`.
- **Backpressure:** hold `out_ready = 0` for 5 cycles -> queue holds entries at 0 and 4, and `fetch_addr` stalls at 8. Release -> pc 0, 4, 8 appear with no gap and no duplicates.
- **Redirect:** redirect to 32'h20 while a pop is presented -> that pop is discarded, `out_valid = 0` for one cycle, then `out_pc = 32'h20` with its instruction.
- **Full simultaneous push/pop:** full queue with `out_ready = 1` -> occupancy stays at `QUEUE_DEPTH`, one instruction per cycle.
- **Illegal address:**
  - Sequential fetch reaches 4*MEM_SIZE -> `fault` rises and `fetch_addr` holds.
  - Queued entries drain, and a later redirect to 0 is ignored.
  - Separately, a redirect to 32'h3 -> `fault` rises one cycle later.
- **Reset mid-operation:** assert `reset = 0` between clock edges with the queue full and in `HALT` -> outputs go to reset values immediately. After release, fetching restarts at `RESET_PC`.
